fifo_rd_streamer: RTL and testbench

- Read-side drain stage sitting directly downstream of the team's synchronous FIFO (FIFO_WIDTH-wide, 1-cycle read latency).
- Issues rd_en to the FIFO, captures data_out into a 3-entry skid buffer and presents it as a valid/ready stream.
- Marks burst boundaries with m_last, counts delivered beats and flags FIFO underflow.
- Sustains one word per cycle without a combinational m_ready-to-rd_en path.

---
 rtl/fifo_rd_streamer_if.sv | 14 +
 rtl/fifo_rd_streamer.sv | 153 +++++++++++++++
 tb/tb_fifo_rd_streamer.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_streamer_if.sv
// Stream-side valid/ready bundle for fifo_rd_streamer.
// master: the streamer driving data toward the consumer.
// slave: the downstream consumer.
interface fifo_rd_streamer_if #(
  parameter int FIFO_WIDTH = 16
);
  logic [FIFO_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_last;

  modport master (output m_data, output m_valid, output m_last, input m_ready);
  modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/fifo_rd_streamer.sv
// Read-side drain stage for a 1-cycle-latency synchronous FIFO.
// Reads are issued against registered occupancy, so m_ready never reaches
// fifo_rd_en combinationally. The 3-entry skid buffer absorbs the words
// already requested when the consumer stalls. Bursts are marked with m_last,
// delivered beats are counted, and FIFO underflow is latched as a sticky flag.
module fifo_rd_streamer #(
  parameter int FIFO_WIDTH = 16,
  parameter int BURST_LEN  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  output logic                  fifo_rd_en,
  fifo_rd_streamer_if.master    m,
  output logic [CNT_WIDTH-1:0]  beat_cnt,
  output logic                  err_underflow
);

  localparam int BCNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BCNT_W-1:0] BCNT_MAX = BCNT_W'(BURST_LEN - 1);

  logic [FIFO_WIDTH-1:0] skid_r [3];
  logic [1:0]            head_r;
  logic [1:0]            tail_r;
  logic [1:0]            occ_r;
  logic                  inflight_r;
  logic [BCNT_W-1:0]     bcnt_r;
  logic [CNT_WIDTH-1:0]  beat_cnt_r;
  logic                  err_r;

  logic                  valid_s;
  logic                  xfer_s;
  logic                  room_s;
  logic                  rd_en_s;

  // Circular pointer over the three skid slots.
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    if (p == 2'd2) begin
      ptr_inc = 2'd0;
    end else begin
      ptr_inc = p + 2'd1;
    end
  endfunction

  assign valid_s = (occ_r != 2'd0);
  assign xfer_s  = valid_s & m.m_ready;
  // Words buffered plus the one possibly on the FIFO bus must leave a free slot.
  assign room_s  = (({1'b0, occ_r} + {2'b00, inflight_r}) < 3'd3);

  // Read request from registered state and the FIFO flag; forced low in reset.
  always_comb begin
    rd_en_s = 1'b0;
    if (rst) begin
      rd_en_s = 1'b0;
    end else if (en && !fifo_empty && room_s) begin
      rd_en_s = 1'b1;
    end else begin
      rd_en_s = 1'b0;
    end
  end

  // Remember that a read was issued so its data is captured next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_r <= 1'b0;
    end else begin
      inflight_r <= rd_en_s;
    end
  end

  // Capture returning FIFO data at the skid buffer tail.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_r[0] <= '0;
      skid_r[1] <= '0;
      skid_r[2] <= '0;
      tail_r    <= 2'd0;
    end else if (inflight_r) begin
      skid_r[tail_r] <= fifo_data_out;
      tail_r         <= ptr_inc(tail_r);
    end else begin
      tail_r <= tail_r;
    end
  end

  // Advance the head on transfer and track occupancy for capture/transfer mixes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_r <= 2'd0;
      occ_r  <= 2'd0;
    end else begin
      if (xfer_s) begin
        head_r <= ptr_inc(head_r);
      end else begin
        head_r <= head_r;
      end
      case ({inflight_r, xfer_s})
        2'b10:   occ_r <= occ_r + 2'd1;
        2'b01:   occ_r <= occ_r - 2'd1;
        default: occ_r <= occ_r;
      endcase
    end
  end

  // Position within the current burst; wraps after the last beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt_r <= '0;
    end else if (xfer_s) begin
      if (bcnt_r == BCNT_MAX) begin
        bcnt_r <= '0;
      end else begin
        bcnt_r <= bcnt_r + BCNT_W'(1);
      end
    end else begin
      bcnt_r <= bcnt_r;
    end
  end

  // Free-running count of delivered beats, wrapping naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt_r <= '0;
    end else if (xfer_s) begin
      beat_cnt_r <= beat_cnt_r + CNT_WIDTH'(1);
    end else begin
      beat_cnt_r <= beat_cnt_r;
    end
  end

  // Sticky underflow flag; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (fifo_underflow) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign fifo_rd_en    = rd_en_s;
  assign m.m_valid     = valid_s;
  assign m.m_data      = skid_r[head_r];
  assign m.m_last      = valid_s & (bcnt_r == BCNT_MAX);
  assign beat_cnt      = beat_cnt_r;
  assign err_underflow = err_r;

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Bench for fifo_rd_streamer: a queue-based FIFO model feeds the DUT, a
// transaction-level model (words requested vs. words delivered) predicts
// every output each cycle, and directed scenarios pin literal values.
module tb_fifo_rd_streamer;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] fifo_data_out;
  logic        fifo_empty;
  logic        fifo_underflow;
  logic        fifo_rd_en;
  logic [15:0] beat_cnt;
  logic        err_underflow;

  fifo_rd_streamer_if #(.FIFO_WIDTH(16)) sif ();

  fifo_rd_streamer #(
    .FIFO_WIDTH(16),
    .BURST_LEN (4),
    .CNT_WIDTH (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .fifo_data_out (fifo_data_out),
    .fifo_empty    (fifo_empty),
    .fifo_underflow(fifo_underflow),
    .fifo_rd_en    (fifo_rd_en),
    .m             (sif),
    .beat_cnt      (beat_cnt),
    .err_underflow (err_underflow)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Upstream FIFO contents and words it has handed out (in order).
  logic [15:0] fq[$];
  logic [15:0] popped_q[$];
  logic [15:0] w_pop;

  // Transaction-level model state.
  int issued    = 0;
  int delivered = 0;
  bit last_rd   = 0;
  bit err_m     = 0;

  // Observation logs for directed checks.
  int          rd_cycles[$];
  logic [15:0] xd[$];
  bit          xl[$];
  int          xc[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] w);
    fq.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic clear_logs();
    rd_cycles.delete();
    xd.delete();
    xl.delete();
    xc.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fq.delete();
    fifo_empty = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Synchronous FIFO model: 1-cycle read latency.
  always @(posedge clk) begin
    cyc++;
    if (fifo_rd_en && fq.size() > 0) begin
      w_pop = fq.pop_front();
      fifo_data_out <= w_pop;
      popped_q.push_back(w_pop);
      fifo_empty <= (fq.size() == 0);
    end
  end

  // Per-cycle compare against the transaction model, then advance the model.
  always @(negedge clk) begin
    int  outst;
    int  occ_m;
    bit  ev;
    bit  er;
    if (rst) begin
      chk("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
      chk("rst_valid", {31'd0, sif.m_valid}, 32'd0);
      chk("rst_last",  {31'd0, sif.m_last}, 32'd0);
      chk("rst_data",  {16'd0, sif.m_data}, 32'd0);
      chk("rst_beat",  {16'd0, beat_cnt}, 32'd0);
      chk("rst_err",   {31'd0, err_underflow}, 32'd0);
      issued = 0;
      delivered = 0;
      last_rd = 0;
      err_m = 0;
      popped_q.delete();
    end else begin
      outst = issued - delivered;
      occ_m = outst - int'(last_rd);
      ev = (occ_m != 0);
      er = en && !fifo_empty && (outst < 3);
      chk("rd_en",   {31'd0, fifo_rd_en}, {31'd0, er});
      chk("m_valid", {31'd0, sif.m_valid}, {31'd0, ev});
      chk("m_last",  {31'd0, sif.m_last},
          {31'd0, ev && ((delivered % 4) == 3)});
      chk("beat_cnt", {16'd0, beat_cnt}, 32'(delivered % 65536));
      chk("err",     {31'd0, err_underflow}, {31'd0, err_m});
      if (ev && popped_q.size() > 0)
        chk("m_data", {16'd0, sif.m_data}, {16'd0, popped_q[0]});
      if (fifo_rd_en) rd_cycles.push_back(cyc);
      if (sif.m_valid && sif.m_ready) begin
        xd.push_back(sif.m_data);
        xl.push_back(sif.m_last);
        xc.push_back(cyc);
      end
      if (ev && sif.m_ready) begin
        if (popped_q.size() > 0) void'(popped_q.pop_front());
        delivered++;
      end
      if (er) issued++;
      last_rd = er;
      if (fifo_underflow) err_m = 1;
    end
  end

  initial begin
    rst = 1'b1;
    en = 1'b0;
    sif.m_ready = 1'b0;
    fifo_underflow = 1'b0;
    fifo_empty = 1'b1;
    fifo_data_out = 16'h0000;
    tick();
    tick();
    chk("init_valid", {31'd0, sif.m_valid}, 32'd0);
    chk("init_beat",  {16'd0, beat_cnt}, 32'd0);
    rst = 1'b0;
    tick();

    // Streaming five words.
    sif.m_ready = 1'b1;
    clear_logs();
    for (int i = 1; i <= 5; i++) push(16'(i));
    en = 1'b1;
    repeat (10) tick();
    chk("strm_rd_pulses", rd_cycles.size(), 32'd5);
    if (rd_cycles.size() == 5) chk("strm_rd_span", rd_cycles[4] - rd_cycles[0], 32'd4);
    chk("strm_beats", xd.size(), 32'd5);
    if (xd.size() == 5 && rd_cycles.size() > 0) begin
      for (int i = 0; i < 5; i++) begin
        chk("strm_data", {16'd0, xd[i]}, 32'(i + 1));
        chk("strm_cycle", xc[i], rd_cycles[0] + 2 + i);
      end
    end
    chk("strm_beat_cnt", {16'd0, beat_cnt}, 32'd5);
    chk("strm_rd_idle", {31'd0, fifo_rd_en}, 32'd0);

    // Underflow pulse: flag appears the cycle after it is sampled.
    fifo_underflow = 1'b1;
    chk("uf_before", {31'd0, err_underflow}, 32'd0);
    tick();
    fifo_underflow = 1'b0;
    chk("uf_after", {31'd0, err_underflow}, 32'd1);

    // Reset mid-operation with two words buffered.
    sif.m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(16'h0A01 + 16'(i));
    tick();
    tick();
    tick();
    chk("pre_rst_valid", {31'd0, sif.m_valid}, 32'd1);
    chk("pre_rst_occ", {30'd0, dut.occ_r}, 32'd2);
    chk("pre_rst_err", {31'd0, err_underflow}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("async_valid", {31'd0, sif.m_valid}, 32'd0);
    chk("async_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    chk("async_last",  {31'd0, sif.m_last}, 32'd0);
    chk("async_beat",  {16'd0, beat_cnt}, 32'd0);
    chk("async_err",   {31'd0, err_underflow}, 32'd0);
    tick();
    rst = 1'b0;
    repeat (4) tick();

    // Backpressure: eight words, consumer stalled.
    do_reset();
    en = 1'b1;
    sif.m_ready = 1'b0;
    clear_logs();
    for (int i = 1; i <= 8; i++) push(16'(i));
    repeat (10) tick();
    chk("bp_rd_pulses", rd_cycles.size(), 32'd3);
    chk("bp_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    chk("bp_hold_data", {16'd0, sif.m_data}, 32'd1);
    chk("bp_hold_valid", {31'd0, sif.m_valid}, 32'd1);
    sif.m_ready = 1'b1;
    repeat (14) tick();
    chk("bp_beats", xd.size(), 32'd8);
    if (xd.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        chk("bp_data", {16'd0, xd[i]}, 32'(i + 1));
        chk("bp_nogap", xc[i], xc[0] + i);
      end
    end
    chk("bp_beat_cnt", {16'd0, beat_cnt}, 32'd8);

    // Bursts of four over ten words.
    do_reset();
    sif.m_ready = 1'b1;
    en = 1'b1;
    clear_logs();
    for (int i = 1; i <= 10; i++) push(16'(i));
    repeat (16) tick();
    chk("burst_beats", xd.size(), 32'd10);
    if (xd.size() == 10) begin
      for (int i = 0; i < 10; i++)
        chk("burst_last", {31'd0, xl[i]}, {31'd0, (i == 3) || (i == 7)});
    end
    chk("burst_bcnt", 32'(dut.bcnt_r), 32'd2);

    // Enable gating after two reads.
    do_reset();
    en = 1'b0;
    sif.m_ready = 1'b1;
    for (int i = 1; i <= 6; i++) push(16'(i));
    clear_logs();
    en = 1'b1;
    tick();
    tick();
    en = 1'b0;
    repeat (8) tick();
    chk("en_rd_pulses", rd_cycles.size(), 32'd2);
    chk("en_beats", xd.size(), 32'd2);
    if (xd.size() >= 2) begin
      chk("en_data0", {16'd0, xd[0]}, 32'd1);
      chk("en_data1", {16'd0, xd[1]}, 32'd2);
    end
    chk("en_rd_off", {31'd0, fifo_rd_en}, 32'd0);
    chk("en_fifo_full", {31'd0, fifo_empty}, 32'd0);
    en = 1'b1;
    repeat (10) tick();
    chk("en_resume_beats", xd.size(), 32'd6);
    if (xd.size() >= 3) chk("en_resume_data", {16'd0, xd[2]}, 32'd3);

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      en = ($urandom_range(0, 9) < 8);
      sif.m_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 1) == 1) push(16'($urandom));
      fifo_underflow = ($urandom_range(0, 49) == 0);
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;
    fifo_underflow = 1'b0;
    en = 1'b1;
    sif.m_ready = 1'b1;
    repeat (40) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
